// File: rtl/input_conditioner_bank.sv
// Per-channel synchronizer, debouncer and edge detector for raw board inputs.
// Define INPUT_COND_SYNC3_EN for a three-flop synchronizer (one extra cycle of latency).
module input_conditioner_bank #(
    parameter int CHANNELS  = 3,
    parameter int WAIT_TIME = 3,
    parameter int CW        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] pos_edge,
    output logic [CHANNELS-1:0] neg_edge
);

    localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_TIME);

    logic [CHANNELS-1:0] s0;
    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] synced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= noisy_in;
            s1 <= s0;
        end
    end

`ifdef INPUT_COND_SYNC3_EN
    logic [CHANNELS-1:0] s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2 <= '0;
        end else begin
            s2 <= s1;
        end
    end

    assign synced = s2;
`else
    assign synced = s1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CW-1:0] cnt;

        // The count only grows while synced disagrees; any agreement restarts it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt            <= '0;
                conditioned[i] <= 1'b0;
                pos_edge[i]    <= 1'b0;
                neg_edge[i]    <= 1'b0;
            end else begin
                pos_edge[i] <= 1'b0;
                neg_edge[i] <= 1'b0;
                if (synced[i] == conditioned[i]) begin
                    cnt <= '0;
                end else if (cnt == WAIT_CNT) begin
                    cnt            <= '0;
                    conditioned[i] <= synced[i];
                    pos_edge[i]    <= synced[i];
                    neg_edge[i]    <= ~synced[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Randomized and directed bench for input_conditioner_bank.
// Honours INPUT_COND_SYNC3_EN for the synchronizer depth of the reference model.
module tb_input_conditioner_bank;

    localparam int CH = 3;
    localparam int WT = 3;
`ifdef INPUT_COND_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    localparam int LAT = WT + 1 + SYNC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] noisy_in = '0;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] pos_edge;
    logic [CH-1:0] neg_edge;

    int checks = 0;
    int errors = 0;

    // Reference model: delay line, then "follow after WT+1 mismatched cycles".
    logic [CH-1:0] hist [SYNC];
    logic [CH-1:0] m_cond;
    logic [CH-1:0] m_pos;
    logic [CH-1:0] m_neg;
    int            run [CH];

    input_conditioner_bank #(
        .CHANNELS (CH),
        .WAIT_TIME(WT),
        .CW       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .noisy_in   (noisy_in),
        .conditioned(conditioned),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < SYNC; k++) hist[k] = '0;
        m_cond = '0;
        m_pos  = '0;
        m_neg  = '0;
        for (int i = 0; i < CH; i++) run[i] = 0;
    endtask

    task automatic step(input logic [CH-1:0] v, input logic r);
        logic [CH-1:0] syn;
        @(negedge clk);
        noisy_in = v;
        reset    = r;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            syn   = hist[SYNC-1];
            m_pos = '0;
            m_neg = '0;
            for (int i = 0; i < CH; i++) begin
                if (syn[i] != m_cond[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == WT + 1) begin
                        m_cond[i] = syn[i];
                        if (syn[i]) m_pos[i] = 1'b1;
                        else        m_neg[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({conditioned, pos_edge, neg_edge} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b %b %b want 000 000 000",
                     conditioned, pos_edge, neg_edge);
        end
        step('0, 1'b1);
        step('0, 1'b1);
    endtask

    task automatic test_clean_rise();
        step('0, 1'b1);
        for (int e = 1; e <= LAT + 2; e++) begin
            step(3'b001, 1'b0);
            checks++;
            if (pos_edge !== ((e == LAT) ? 3'b001 : 3'b000) ||
                conditioned !== ((e >= LAT) ? 3'b001 : 3'b000) ||
                neg_edge !== 3'b000) begin
                errors++;
                $display("FAIL clean_rise edge %0d got c=%b p=%b n=%b",
                         e, conditioned, pos_edge, neg_edge);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        step('0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            for (int h = 0; h < 2; h++) begin
                step((b % 2 == 0) ? 3'b010 : 3'b000, 1'b0);
                checks++;
                if (pos_edge[1] !== 1'b0 || conditioned[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_reject b=%0d got c=%b p=%b want 0 0",
                             b, conditioned[1], pos_edge[1]);
                end
            end
        end
        for (int e = 1; e <= LAT + 3; e++) begin
            step(3'b010, 1'b0);
            if (pos_edge[1]) pulses++;
            checks++;
            if (pos_edge[1] !== (e == LAT)) begin
                errors++;
                $display("FAIL bounce_settle edge %0d got p=%b want %b",
                         e, pos_edge[1], (e == LAT));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_falling();
        step('0, 1'b1);
        for (int e = 0; e < LAT + 4; e++) step(3'b100, 1'b0);
        checks++;
        if (conditioned !== 3'b100) begin
            errors++;
            $display("FAIL falling_setup got %b want 100", conditioned);
        end
        for (int e = 1; e <= LAT + 2; e++) begin
            step(3'b000, 1'b0);
            checks++;
            if (neg_edge[2] !== (e == LAT) || pos_edge[2] !== 1'b0 ||
                conditioned[2] !== (e < LAT)) begin
                errors++;
                $display("FAIL falling edge %0d got c=%b p=%b n=%b",
                         e, conditioned[2], pos_edge[2], neg_edge[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step('0, 1'b1);
        for (int e = 1; e <= 3; e++) step(3'b001, 1'b0);
        for (int e = 0; e < 2; e++) begin
            step(3'b001, 1'b1);
            checks++;
            if ({conditioned, pos_edge, neg_edge} !== '0) begin
                errors++;
                $display("FAIL reset_mid_hold got c=%b p=%b n=%b want zeros",
                         conditioned, pos_edge, neg_edge);
            end
        end
        for (int e = 1; e <= LAT + 2; e++) begin
            step(3'b001, 1'b0);
            checks++;
            if (pos_edge !== ((e == LAT) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL reset_mid_release edge %0d got p=%b", e, pos_edge);
            end
        end
    endtask

    task automatic test_simultaneous();
        step('0, 1'b1);
        for (int e = 1; e <= LAT + 2; e++) begin
            step(3'b111, 1'b0);
            checks++;
            if (pos_edge !== ((e == LAT) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL simultaneous edge %0d got p=%b want %b",
                         e, pos_edge, (e == LAT) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] cur;
        logic [CH-1:0] prev_pulse;
        logic          r;
        cur = '0;
        prev_pulse = '0;
        step('0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(5) == 0) cur[i] = ~cur[i];
            r = ($urandom_range(249) == 0);
            step(cur, r);
            checks++;
            if (conditioned !== m_cond || pos_edge !== m_pos ||
                neg_edge !== m_neg) begin
                errors++;
                $display("FAIL random n=%0d got c=%b p=%b n=%b want %b %b %b",
                         n, conditioned, pos_edge, neg_edge, m_cond, m_pos, m_neg);
            end
            checks++;
            if ((pos_edge & neg_edge) !== '0 ||
                ((pos_edge | neg_edge) & prev_pulse) !== '0) begin
                errors++;
                $display("FAIL random_pulse_shape n=%0d got p=%b n=%b prev=%b",
                         n, pos_edge, neg_edge, prev_pulse);
            end
            prev_pulse = pos_edge | neg_edge;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_rise();
        test_bounce();
        test_falling();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
